// File: rtl/riscv_wb_pkg.sv
// Shared constants and the result-entry type for the writeback sequencer.
// No ports. Optional feature macro used elsewhere: WB_LOAD_BYPASS_EN.
package riscv_wb_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_DEPTH   = 2;
  localparam int unsigned CNT_W      = $clog2(WB_DEPTH + 1);

  // One completed load waiting for the register-file write port.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);
endpackage

// File: rtl/wb_sequencer_if.sv
// Bus bundle between the execution units / register file and the sequencer.
// Inputs to the sequencer: alu_valid/alu_rd/alu_data, lsu_issue/lsu_issue_rd,
// lsu_valid/lsu_data. Outputs: rf_we/rf_waddr/rf_wd, busy_mask, stall,
// waw_hazard, err. master drives the inputs, slave is the sequencer.
interface wb_sequencer_if;
  import riscv_wb_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_issue;
  logic [REG_ADDR_W-1:0] lsu_issue_rd;
  logic                  lsu_valid;
  logic [XLEN-1:0]       lsu_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wd;
  logic [XLEN-1:0]       busy_mask;
  logic                  stall;
  logic                  waw_hazard;
  logic                  err;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_issue, lsu_issue_rd, lsu_valid, lsu_data,
    input  rf_we, rf_waddr, rf_wd, busy_mask, stall, waw_hazard, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_issue, lsu_issue_rd, lsu_valid, lsu_data,
    output rf_we, rf_waddr, rf_wd, busy_mask, stall, waw_hazard, err
  );
endinterface

// File: rtl/wb_fifo.sv
// Small shift-style synchronous FIFO; slot 0 is always the head and valid
// bits stay contiguous from slot 0, so every entry is visible to the parent.
// Ports: clk, rst_n (async active-low), push/wdata, pop, entries (all slots),
// valid (per-slot), count. Push to a full FIFO and pop of an empty one are
// ignored; push and pop in the same cycle are both honoured.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            valid,
  output logic [CNT_W-1:0]            count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic                        placed;

  // Next state: shift down on pop, then fill the first free slot on push.
  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    placed = 1'b0;
    if (pop && vld_q[0]) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!vld_d[i] && !placed) begin
          mem_d[i] = wdata;
          vld_d[i] = 1'b1;
          placed   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      vld_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
    end
  end

  // Occupancy from the registered valid bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count = count + CNT_W'(vld_q[i]);
    end
  end

  assign entries = mem_q;
  assign valid   = vld_q;
endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: merges single-cycle ALU results and in-order load
// responses onto one register-file write port, tracking outstanding loads.
// Ports: clk, async_reset (async active-low), wb (wb_sequencer_if.slave).
// Write port and hazard outputs are combinational; err is a sticky register.
// Macro WB_LOAD_BYPASS_EN: when defined, a completing load is written in its
// completion cycle if the port is otherwise idle; otherwise it always takes
// one cycle through the result FIFO.
module wb_sequencer
  import riscv_wb_pkg::*;
(
  input  logic           clk,
  input  logic           async_reset,
  wb_sequencer_if.slave  wb
);
  logic [WB_DEPTH-1:0][REG_ADDR_W-1:0] tag_entries;
  logic [WB_DEPTH-1:0]                 tag_vld;
  logic [CNT_W-1:0]                    tag_cnt;
  logic [WB_DEPTH-1:0][ENTRY_W-1:0]    res_entries;
  logic [WB_DEPTH-1:0]                 res_vld;
  logic [CNT_W-1:0]                    res_cnt;

  logic            stall_i, issue_ok, load_done, res_pop, res_push, bypass;
  logic            sel_valid, we_c, err_q;
  wb_entry_t       load_entry, res_head, sel, scan;
  logic [XLEN-1:0] busy;

  // Completions move a tag into the result FIFO, so the combined count
  // is the true number of loads not yet written back.
  assign stall_i   = ((CNT_W+1)'(tag_cnt) + (CNT_W+1)'(res_cnt)) == (CNT_W+1)'(WB_DEPTH);
  assign issue_ok  = wb.lsu_issue & ~stall_i;
  assign load_done = wb.lsu_valid & tag_vld[0];

  assign load_entry.rd   = tag_entries[0];
  assign load_entry.data = wb.lsu_data;
  assign res_head        = wb_entry_t'(res_entries[0]);

  // Write-port arbitration: ALU, then buffered load, then bypassed load.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    res_pop   = 1'b0;
    bypass    = 1'b0;
    if (wb.alu_valid) begin
      sel_valid = 1'b1;
      sel.rd    = wb.alu_rd;
      sel.data  = wb.alu_data;
    end else if (res_vld[0]) begin
      sel_valid = 1'b1;
      sel       = res_head;
      res_pop   = 1'b1;
    end
`ifdef WB_LOAD_BYPASS_EN
    else if (load_done) begin
      sel_valid = 1'b1;
      sel       = load_entry;
      bypass    = 1'b1;
    end
`endif
  end

  assign res_push = load_done & ~bypass;

  // x0 writes consume their source but never reach the register file.
  assign we_c        = sel_valid & (sel.rd != '0) & async_reset;
  assign wb.rf_we    = we_c;
  assign wb.rf_waddr = we_c ? sel.rd : '0;
  assign wb.rf_wd    = we_c ? sel.data : '0;

  // Destinations of every load not yet written back.
  always_comb begin
    busy = '0;
    scan = '0;
    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      if (tag_vld[i]) busy[tag_entries[i]] = 1'b1;
      scan = wb_entry_t'(res_entries[i]);
      if (res_vld[i]) busy[scan.rd] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign wb.busy_mask  = busy;
  assign wb.stall      = stall_i;
  assign wb.waw_hazard = wb.alu_valid & busy[wb.alu_rd];
  assign wb.err        = err_q;

  // Sticky protocol error: issue while full, or response with no load pending.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      err_q <= 1'b0;
    end else if ((wb.lsu_issue && stall_i) || (wb.lsu_valid && !tag_vld[0])) begin
      err_q <= 1'b1;
    end
  end

  wb_fifo #(.WIDTH(REG_ADDR_W), .DEPTH(WB_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (async_reset),
    .push    (issue_ok),
    .wdata   (wb.lsu_issue_rd),
    .pop     (wb.lsu_valid),
    .entries (tag_entries),
    .valid   (tag_vld),
    .count   (tag_cnt)
  );

  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(WB_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst_n   (async_reset),
    .push    (res_push),
    .wdata   (load_entry),
    .pop     (res_pop),
    .entries (res_entries),
    .valid   (res_vld),
    .count   (res_cnt)
  );
endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios followed by random
// traffic, all checked against a queue-based model of outstanding loads.
module tb_wb_sequencer;
  import riscv_wb_pkg::*;

  logic clk = 1'b0;
  logic async_reset = 1'b1;
  always #5 clk = ~clk;

  wb_sequencer_if bus ();
  wb_sequencer dut (.clk(clk), .async_reset(async_reset), .wb(bus));

  int total = 0;
  int bad   = 0;

  logic [4:0]  tq[$];      // outstanding loads, issue order
  wb_entry_t   rq[$];      // completed loads awaiting the write port
  logic        m_err;
  logic [31:0] dut_rf[32]; // register file as seen through the DUT's writes
  int          wlog[$];    // addresses written, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    foreach (tq[i]) if (tq[i] != 0) b[tq[i]] = 1'b1;
    foreach (rq[i]) if (rq[i].rd != 0) b[rq[i].rd] = 1'b1;
    return b;
  endfunction

  function automatic bit m_stall();
    return (tq.size() + rq.size()) == 2;
  endfunction

  // One clock: drive inputs, check all outputs mid-cycle, then advance the model.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic li, input logic [4:0] lr,
                      input logic lv, input logic [31:0] ld);
    bit          has, use_res, byp, st_pre, tag_empty, exp_we;
    wb_entry_t   w, e;
    logic [31:0] b;
    has = 0; use_res = 0; byp = 0; w = '0; e = '0;
    @(negedge clk);
    bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
    bus.lsu_issue = li; bus.lsu_issue_rd = lr;
    bus.lsu_valid = lv; bus.lsu_data = ld;
    #1;
    if (av) begin
      has = 1; w.rd = ar; w.data = ad;
    end else if (rq.size() > 0) begin
      has = 1; w = rq[0]; use_res = 1;
    end
`ifdef WB_LOAD_BYPASS_EN
    else if (lv && tq.size() > 0) begin
      has = 1; w.rd = tq[0]; w.data = ld; byp = 1;
    end
`endif
    exp_we = has && (w.rd != 0);
    b = m_busy();
    st_pre = m_stall();
    chk("rf_we", 32'(bus.rf_we), 32'(exp_we));
    chk("rf_waddr", 32'(bus.rf_waddr), exp_we ? 32'(w.rd) : 32'd0);
    chk("rf_wd", bus.rf_wd, exp_we ? w.data : 32'd0);
    chk("busy_mask", bus.busy_mask, b);
    chk("stall", 32'(bus.stall), 32'(st_pre));
    chk("waw_hazard", 32'(bus.waw_hazard), 32'(av && b[ar]));
    chk("err", 32'(bus.err), 32'(m_err));
    if (bus.rf_we === 1'b1) begin
      dut_rf[bus.rf_waddr] = bus.rf_wd;
      wlog.push_back(int'(bus.rf_waddr));
    end
    @(posedge clk);
    tag_empty = (tq.size() == 0);
    if (use_res) void'(rq.pop_front());
    if (lv && !tag_empty) begin
      e.rd = tq.pop_front();
      e.data = ld;
      if (!byp) rq.push_back(e);
    end
    if (li && !st_pre) tq.push_back(lr);
    if ((li && st_pre) || (lv && tag_empty)) m_err = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  // Reset asserted between edges with an ALU write pending: all must clear at once.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hCAFE0001;
    bus.lsu_issue = 1'b0; bus.lsu_valid = 1'b0;
    #2 async_reset = 1'b0;
    #1;
    chk({tag, "_busy"}, bus.busy_mask, 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    async_reset = 1'b1;
    bus.alu_valid = 1'b0;
    tq.delete(); rq.delete(); m_err = 1'b0;
  endtask

  initial begin
    bit av, li, lv;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_issue = 0; bus.lsu_issue_rd = 0; bus.lsu_valid = 0; bus.lsu_data = 0;
    m_err = 1'b0;
    foreach (dut_rf[i]) dut_rf[i] = 32'd0;

    mid_reset("reset");

    // ALU write appears in the same cycle.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'd0);
    chk("x5_value", dut_rf[5], 32'hDEADBEEF);

    // x0: ALU write suppressed, load to x0 never marks busy.
    step(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 1'b0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 32'd0);
    idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h77);
    idle();
    chk("x0_value", dut_rf[0], 32'd0);

    // Load completes under an ALU write; load follows next cycle.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0);
    step(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 1'b1, 32'h1234);
    idle();
    idle();
    chk("x3_value", dut_rf[3], 32'h3333);
    chk("x7_value", dut_rf[7], 32'h1234);

    // Capacity: two loads fill it, third issue dropped, writes in order.
    wlog.delete();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h88);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h99);
    idle();
    idle();
    chk("cap_err", 32'(bus.err), 32'd1);
    chk("cap_writes", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      chk("cap_first", 32'(wlog[0]), 32'd8);
      chk("cap_second", 32'(wlog[1]), 32'd9);
    end

    // WAW: ALU write to a busy register, load value lands last.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 32'd0);
    step(1'b1, 5'd4, 32'hAAAA, 1'b0, 5'd0, 1'b0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h5555);
    idle();
    chk("x4_value", dut_rf[4], 32'h5555);

    // Reset with two loads outstanding; a stray response then flags err.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 32'd0);
    mid_reset("mid_reset");
    wlog.delete();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hBAD);
    idle();
    chk("post_reset_err", 32'(bus.err), 32'd1);
    chk("post_reset_writes", 32'(wlog.size()), 32'd0);

    // Random legal traffic.
    mid_reset("rand_reset");
    for (int n = 0; n < 400; n++) begin
      av = ($urandom_range(0, 2) == 0);
      li = ($urandom_range(0, 1) == 1) && !m_stall();
      lv = (tq.size() > 0) && ($urandom_range(0, 2) != 0);
      step(av, 5'($urandom_range(0, 31)), $urandom, li, 5'($urandom_range(0, 31)),
           lv, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port async_reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port alu_valid, input, 1 bit: a single-cycle result is present this cycle.
REQ-004 SHALL have ports alu_rd (input, 5 bits) and alu_data (input, 32 bits): destination and value of the single-cycle result.
REQ-005 SHALL have ports lsu_issue (input, 1 bit) and lsu_issue_rd (input, 5 bits): a load is issued, with its destination register.
REQ-006 SHALL have ports lsu_valid (input, 1 bit) and lsu_data (input, 32 bits): load response, returned in issue order.
REQ-007 SHALL have ports rf_we (output, 1 bit), rf_waddr (output, 5 bits) and rf_wd (output, 32 bits): the register-file write port, named WE/W_addr/WD at the register file.
REQ-008 SHALL have port busy_mask, output, 32 bits: bit n is set while a load to xn is outstanding.
REQ-009 SHALL have ports stall (output, 1 bit): no load capacity left; and waw_hazard (output, 1 bit): alu_valid targets a busy register.
REQ-010 SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-011 SHALL hold a 2-entry tag FIFO of outstanding load rd values and a 2-entry result FIFO of {rd, data} pairs.
REQ-012 lsu_issue with stall low SHALL push lsu_issue_rd into the tag FIFO at the clock edge.
REQ-013 lsu_valid SHALL pop the tag-FIFO head and pair it with lsu_data as a completed load.
REQ-014 stall SHALL equal (tag_count + result_count == 2), evaluated from registered state.
REQ-015 Write-port priority each cycle: first alu_valid, then the result-FIFO head, then the bypassed completed load (REQ-025).
REQ-016 A completed load that is not written in the cycle it completes SHALL be pushed into the result FIFO.
REQ-017 rf_we SHALL be 0 when the selected write targets x0; the source entry is still consumed.
REQ-018 rf_we, rf_waddr and rf_wd SHALL be combinational from current state and inputs, giving zero-cycle latency for ALU writes.
REQ-019 With nothing to write, rf_we SHALL be 0 and rf_waddr and rf_wd SHALL be 0.
REQ-020 busy_mask SHALL be the OR of the one-hot decodes of all valid tag-FIFO and result-FIFO rd values, excluding x0.
REQ-021 waw_hazard SHALL be alu_valid AND busy_mask[alu_rd]; the ALU write still occurs, and the later load write overwrites it in order.
REQ-022 Simultaneous lsu_issue and lsu_valid SHALL perform the pop and the push in the same cycle; stall is evaluated before the pop.
REQ-023 err SHALL set and hold on either condition:
- lsu_issue while stall is high (the issue is dropped);
- lsu_valid with the tag FIFO empty (the response is dropped).

Reset
REQ-024 While async_reset is low, the following SHALL be cleared immediately, independent of clk:
- both FIFOs emptied;
- busy_mask = 0, stall = 0, err = 0;
- rf_we = 0.
Outstanding loads are discarded, and responses arriving after reset set err.

Configuration
REQ-025 Macro WB_LOAD_BYPASS_EN:
- Defined: a completed load SHALL be written in its completion cycle when alu_valid is low and the result FIFO is empty.
- Undefined: every completed load SHALL pass through the result FIFO, adding exactly one cycle of latency; stall accounting is unchanged.

Structure
REQ-026 Package riscv_wb_pkg SHALL hold:
- XLEN = 32, REG_ADDR_W = 5, WB_DEPTH = 2;
- the typedef of the {rd, data} result entry.
REQ-027 Sub-module wb_fifo SHALL be a parameterised synchronous FIFO with asynchronous active-low reset, instantiated for both the tag FIFO and the result FIFO.

Verification
REQ-028 ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> same cycle rf_we=1, rf_waddr=5, rf_wd=0xDEADBEEF.
REQ-029 x0 write: alu_rd=0, alu_data=0x1 -> rf_we=0; a load issued to x0 -> busy_mask stays 0.
REQ-030 Load collision: issue load rd=7, then lsu_valid with data 0x1234 in the same cycle as alu_valid rd=3 -> x3 written that cycle; x7=0x1234 written the next cycle; busy_mask[7] clears after that write.
REQ-031 Capacity: issue loads to rd=8 and rd=9 -> stall=1; a third issue -> dropped, err=1; respond to both -> writes in order 8 then 9.
REQ-032 WAW: load to rd=4 outstanding, alu_valid rd=4 -> waw_hazard=1; x4 ends with the load value.
REQ-033 Reset mid-operation: two loads outstanding, assert async_reset between clock edges -> busy_mask=0 and stall=0 immediately; a subsequent lsu_valid -> err=1 and no write.
